mips_cpu_halt_monitor: RTL and testbench
========================================

# mips_cpu_halt_monitor

Downstream observer for `mips_cpu_harvard`. It consumes the CPU's `active`, `instr_address` and `register_v0` outputs and detects program completion, which is a jump to address 0 with `active` low. At completion it captures the `$v0` result and counts enabled cycles. It also enforces a timeout watchdog and a reset-vector check, so unit benches and the top-level harness get one registered pass/fail interface instead of ad-hoc negedge polling.

## Interface
- `RESET_VECTOR`, default 32'hBFC00000: required address of the first fetch after reset.
- `TIMEOUT_CYCLES`, default 100: maximum enabled cycles in RUN before forced termination; must be ≥ 1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clk_enable`  in  1  same enable the CPU sees; edges with `clk_enable`=0 are ignored entirely.
- `active`  in  1  CPU `active` output.
- `instr_address`  in  32  CPU instruction fetch address.
- `register_v0`  in  32  CPU `$v0` debug output.
- `done`  out  1  program terminated, by halt or by timeout; sticky until reset.
- `timed_out`  out  1  termination was caused by the watchdog.
- `bad_halt`  out  1  `active` fell while `instr_address` ≠ 0.
- `vector_err`  out  1  first enabled fetch after reset ≠ `RESET_VECTOR`; sticky.
- `result`  out  32  `register_v0` sampled at the halt edge.
- `cycle_count`  out  32  enabled RUN edges, including the terminating edge.
- `last_pc`  out  32  last `instr_address` sampled while `active`=1.

## Operation
- States: RUN, HALTED, TIMEOUT. HALTED and TIMEOUT are terminal until reset.
- Reset state and values:
  - Reset edge: state ← RUN.
  - All outputs ← 0.
  - Internal `first_fetch` flag ← 1.
- RUN, on an enabled edge, evaluated in priority order:
  1. If `first_fetch`=1: `vector_err` ← (`instr_address` ≠ `RESET_VECTOR`), and `first_fetch` ← 0. This check happens on the same edge as the steps below.
  2. `cycle_count` ← `cycle_count`+1.
  3. If `active`=1: `last_pc` ← `instr_address`.
  4. Halt condition is `active`=0. On halt:
     - state ← HALTED, `done` ← 1, `result` ← `register_v0`.
     - `bad_halt` ← (`instr_address` ≠ 0).
  5. Otherwise, if `cycle_count`+1 = `TIMEOUT_CYCLES`: state ← TIMEOUT, `done` ← 1, `timed_out` ← 1. `result` stays 0.
- Simultaneous halt and timeout on the same edge: halt wins and `timed_out` stays 0.
- HALTED / TIMEOUT:
  - All outputs hold.
  - Further CPU activity is ignored, including `active` re-rising.
  - `cycle_count` does not increment.
- Disabled edge (`clk_enable`=0), in any state: no state change, counters frozen, and halt and vector checks are not evaluated.
- Counter width: `cycle_count` is 32-bit and never wraps in practice, because the watchdog terminates first. No saturation logic is needed.

## Timing
- All outputs are registered. Each output reflects the inputs sampled at the rising edge that updated it, so there is 1-cycle latency from input to output.
- `done`, `result` and `cycle_count` change together on the terminating edge. Consumers may sample them on the following negedge.
- `reset` asserted mid-run:
  - On that edge all outputs clear, state goes to RUN and `first_fetch` is re-armed.
  - `reset` overrides `clk_enable`, so reset takes effect even when `clk_enable`=0.
- `reset` held for multiple cycles: outputs stay 0 and nothing is counted.
- The edge after `reset` deasserts is the first RUN edge and performs the vector check.

## Test plan
- **Normal halt.** Setup: reset for 1 edge, `TIMEOUT_CYCLES`=100. Stimulus: five enabled edges with `active`=1 and `instr_address`=BFC00000, BFC00004, …, BFC00010. Then `active`=0, `instr_address`=0, `register_v0`=32'd1. Required: `done`=1, `result`=1, `cycle_count`=6, `last_pc`=BFC00010, and `timed_out`, `bad_halt`, `vector_err` all 0.
- **Watchdog.** Setup: `TIMEOUT_CYCLES`=16, `active` held at 1. Required: after the 16th enabled edge, `done`=1, `timed_out`=1, `cycle_count`=16, `result`=0. Outputs then remain unchanged for 10 further edges.
- **Halt/timeout tie.** Setup: `TIMEOUT_CYCLES`=16, `active`=0 first seen on the 16th enabled edge, `register_v0`=32'hFFFFFFB3. Required: `done`=1, `timed_out`=0, `result`=FFFFFFB3, `cycle_count`=16.
- **Clock enable gating.** Stimulus: `clk_enable`=0 for 5 edges mid-run while `active`=0 and `instr_address`=0 are presented. Required: no halt is taken and `cycle_count` is unchanged. Halt registers on the first edge after `clk_enable` returns to 1.
- **Bad vector and bad halt.** Stimulus: first fetch at 0x00000000 with `active`=1 gives `vector_err`=1. Later `active`=0 with `instr_address`=BFC00008. Required: `done`=1, `bad_halt`=1, `vector_err` still 1.
- **Reset mid-run.** Stimulus: assert `reset` at `cycle_count`=5. Required: all outputs are 0 on the next edge. After release, a correct vector fetch leaves `vector_err`=0 and counting restarts from 1.

Source files
------------

// File: rtl/mips_cpu_halt_monitor.sv
// Halt monitor for mips_cpu_harvard: detects program completion, watchdog timeout and a bad reset
// vector, and presents them as one registered pass/fail interface.
module mips_cpu_halt_monitor #(
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        active,
  input  logic [31:0] instr_address,
  input  logic [31:0] register_v0,
  output logic        done,
  output logic        timed_out,
  output logic        bad_halt,
  output logic        vector_err,
  output logic [31:0] result,
  output logic [31:0] cycle_count,
  output logic [31:0] last_pc
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_HALTED  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        first_fetch_q, first_fetch_d;
  logic        done_q, done_d;
  logic        timed_out_q, timed_out_d;
  logic        bad_halt_q, bad_halt_d;
  logic        vector_err_q, vector_err_d;
  logic [31:0] result_q, result_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] last_pc_q, last_pc_d;

  always_comb begin
    state_d       = state_q;
    first_fetch_d = first_fetch_q;
    done_d        = done_q;
    timed_out_d   = timed_out_q;
    bad_halt_d    = bad_halt_q;
    vector_err_d  = vector_err_q;
    result_d      = result_q;
    cycle_count_d = cycle_count_q;
    last_pc_d     = last_pc_q;

    // Terminal states and disabled edges leave everything untouched.
    if (clk_enable && (state_q == ST_RUN)) begin
      if (first_fetch_q) begin
        vector_err_d  = (instr_address != RESET_VECTOR);
        first_fetch_d = 1'b0;
      end
      cycle_count_d = cycle_count_q + 32'd1;
      if (active) begin
        last_pc_d = instr_address;
      end
      // Halt takes priority over a watchdog expiry on the same edge.
      if (!active) begin
        state_d    = ST_HALTED;
        done_d     = 1'b1;
        result_d   = register_v0;
        bad_halt_d = (instr_address != 32'd0);
      end else if (cycle_count_d == TIMEOUT_CYCLES) begin
        state_d     = ST_TIMEOUT;
        done_d      = 1'b1;
        timed_out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      first_fetch_q <= 1'b1;
      done_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      bad_halt_q    <= 1'b0;
      vector_err_q  <= 1'b0;
      result_q      <= 32'd0;
      cycle_count_q <= 32'd0;
      last_pc_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      first_fetch_q <= first_fetch_d;
      done_q        <= done_d;
      timed_out_q   <= timed_out_d;
      bad_halt_q    <= bad_halt_d;
      vector_err_q  <= vector_err_d;
      result_q      <= result_d;
      cycle_count_q <= cycle_count_d;
      last_pc_q     <= last_pc_d;
    end
  end

  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign bad_halt    = bad_halt_q;
  assign vector_err  = vector_err_q;
  assign result      = result_q;
  assign cycle_count = cycle_count_q;
  assign last_pc     = last_pc_q;

endmodule

// File: tb/tb_mips_cpu_halt_monitor.sv
// Bench for mips_cpu_halt_monitor: two instances (watchdog 100 and 16) share one stimulus stream
// and are compared every edge against a behavioural model, plus directed scenario checks.
module tb_mips_cpu_halt_monitor;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset, clk_enable, active;
  logic [31:0] instr_address, register_v0;

  logic        a_done, a_to, a_bad, a_verr;
  logic [31:0] a_res, a_cnt, a_pc;
  logic        b_done, b_to, b_bad, b_verr;
  logic [31:0] b_res, b_cnt, b_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_cpu_halt_monitor #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(32'd100)) dut_a (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .instr_address(instr_address), .register_v0(register_v0),
    .done(a_done), .timed_out(a_to), .bad_halt(a_bad), .vector_err(a_verr),
    .result(a_res), .cycle_count(a_cnt), .last_pc(a_pc));

  mips_cpu_halt_monitor #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(32'd16)) dut_b (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .instr_address(instr_address), .register_v0(register_v0),
    .done(b_done), .timed_out(b_to), .bad_halt(b_bad), .vector_err(b_verr),
    .result(b_res), .cycle_count(b_cnt), .last_pc(b_pc));

  // Reference model: one record per instance, indexed 0 = dut_a, 1 = dut_b.
  typedef struct {
    bit          done, to, bad, verr, first;
    bit [31:0]   res, cnt, pc;
  } mdl_t;
  mdl_t        m [2];
  int unsigned lim [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m[i] = '{done: 0, to: 0, bad: 0, verr: 0, first: 1, res: 0, cnt: 0, pc: 0};
      end else if (clk_enable && !m[i].done) begin
        if (m[i].first) begin
          m[i].verr  = (instr_address != RV);
          m[i].first = 0;
        end
        m[i].cnt++;
        if (active) m[i].pc = instr_address;
        if (!active) begin
          m[i].done = 1;
          m[i].res  = register_v0;
          m[i].bad  = (instr_address != 0);
        end else if (m[i].cnt == lim[i]) begin
          m[i].done = 1;
          m[i].to   = 1;
        end
      end
    end
  endtask

  task automatic cmp_dut(input int i, input logic d, input logic t, input logic b, input logic v,
                         input logic [31:0] r, input logic [31:0] c, input logic [31:0] p);
    check($sformatf("u%0d.done", i), {31'd0, d}, {31'd0, m[i].done});
    check($sformatf("u%0d.timed_out", i), {31'd0, t}, {31'd0, m[i].to});
    check($sformatf("u%0d.bad_halt", i), {31'd0, b}, {31'd0, m[i].bad});
    check($sformatf("u%0d.vector_err", i), {31'd0, v}, {31'd0, m[i].verr});
    check($sformatf("u%0d.result", i), r, m[i].res);
    check($sformatf("u%0d.cycle_count", i), c, m[i].cnt);
    check($sformatf("u%0d.last_pc", i), p, m[i].pc);
  endtask

  // Apply one set of inputs across one rising edge, then compare both instances.
  task automatic step(input logic rst, input logic en, input logic act,
                      input logic [31:0] addr, input logic [31:0] v0);
    reset = rst; clk_enable = en; active = act; instr_address = addr; register_v0 = v0;
    @(posedge clk);
    model_edge();
    #1;
    cmp_dut(0, a_done, a_to, a_bad, a_verr, a_res, a_cnt, a_pc);
    cmp_dut(1, b_done, b_to, b_bad, b_verr, b_res, b_cnt, b_pc);
  endtask

  initial begin
    lim[0] = 100;
    lim[1] = 16;
    for (int i = 0; i < 2; i++) m[i] = '{default: 0};
    m[0].first = 1; m[1].first = 1;
    reset = 1; clk_enable = 0; active = 1; instr_address = 0; register_v0 = 0;

    // Reset state, applied with clk_enable low.
    step(1, 0, 1, 32'h1234, 32'h55);
    check("rst.done", {31'd0, a_done}, 32'd0);
    check("rst.cycle_count", a_cnt, 32'd0);

    // Normal halt
    step(1, 1, 1, RV, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 1, RV + 32'(4 * k), 32'h7);
    step(0, 1, 0, 0, 32'd1);
    check("halt.done", {31'd0, a_done}, 32'd1);
    check("halt.result", a_res, 32'd1);
    check("halt.cycle_count", a_cnt, 32'd6);
    check("halt.last_pc", a_pc, 32'hBFC00010);
    check("halt.flags", {29'd0, a_to, a_bad, a_verr}, 32'd0);

    // Watchdog on the 16-cycle instance, then hold for 10 edges
    step(1, 1, 1, RV, 0);
    for (int k = 0; k < 16; k++) step(0, 1, 1, RV + 32'(4 * k), 32'hAA);
    check("wd.done", {31'd0, b_done}, 32'd1);
    check("wd.timed_out", {31'd0, b_to}, 32'd1);
    check("wd.cycle_count", b_cnt, 32'd16);
    check("wd.result", b_res, 32'd0);
    for (int k = 0; k < 10; k++) step(0, 1, k[0], 32'(k), 32'hDEAD);
    check("wd.hold_count", b_cnt, 32'd16);
    check("wd.hold_result", b_res, 32'd0);

    // Halt and timeout on the same edge: halt wins
    step(1, 1, 1, RV, 0);
    for (int k = 0; k < 15; k++) step(0, 1, 1, RV + 32'(4 * k), 0);
    step(0, 1, 0, 0, 32'hFFFFFFB3);
    check("tie.done", {31'd0, b_done}, 32'd1);
    check("tie.timed_out", {31'd0, b_to}, 32'd0);
    check("tie.result", b_res, 32'hFFFFFFB3);
    check("tie.cycle_count", b_cnt, 32'd16);

    // Clock enable gating
    step(1, 1, 1, RV, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 1, RV + 32'(4 * k), 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 32'h42);
    check("gate.done", {31'd0, a_done}, 32'd0);
    check("gate.cycle_count", a_cnt, 32'd3);
    step(0, 1, 0, 0, 32'h42);
    check("gate.halt", {31'd0, a_done}, 32'd1);
    check("gate.result", a_res, 32'h42);
    check("gate.cycle_count2", a_cnt, 32'd4);

    // Bad vector then bad halt
    step(1, 1, 1, RV, 0);
    step(0, 1, 1, 0, 0);
    check("vec.err", {31'd0, a_verr}, 32'd1);
    step(0, 1, 1, 32'h4, 0);
    step(0, 1, 0, 32'hBFC00008, 32'h9);
    check("bh.done", {31'd0, a_done}, 32'd1);
    check("bh.bad_halt", {31'd0, a_bad}, 32'd1);
    check("bh.vector_err", {31'd0, a_verr}, 32'd1);

    // Reset mid-run
    step(1, 1, 1, RV, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 1, (k == 0) ? 32'h0 : RV + 32'(4 * k), 0);
    check("mid.pre_count", a_cnt, 32'd5);
    step(1, 0, 1, 32'h8, 32'h3);
    check("mid.cnt", a_cnt, 32'd0);
    check("mid.verr", {31'd0, a_verr}, 32'd0);
    check("mid.pc", a_pc, 32'd0);
    step(0, 1, 1, RV, 0);
    check("mid.verr2", {31'd0, a_verr}, 32'd0);
    check("mid.restart", a_cnt, 32'd1);

    // Randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      int len;
      len = $urandom_range(140, 5);
      step(1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom, $urandom);
      for (int c = 0; c < len; c++) begin
        logic        r, e, a;
        logic [31:0] ad;
        r = ($urandom_range(79, 0) == 0);
        e = ($urandom_range(9, 0) != 0);
        a = ($urandom_range(39, 0) != 0);
        case ($urandom_range(3, 0))
          0:       ad = RV;
          1:       ad = 32'd0;
          default: ad = $urandom;
        endcase
        step(r, e, a, ad, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
